// File: rtl/nbit_2to1_mux.sv
// nbit_2to1_mux: N-bit two-input select element.
// Provides a purely combinational selection result for same-cycle steering
// and an enable-gated registered copy with a "has captured" flag for
// pipelined consumers that need a stable, reset-defined value.
module nbit_2to1_mux #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sel,
    input  logic         en,
    output logic [N-1:0] out,
    output logic [N-1:0] out_q,
    output logic         valid_q
);

    // Bit-sliced selection result shared by both the combinational output
    // and the capture register, so out_q can only ever load what out shows.
    logic [N-1:0] mux_sel;

    logic [N-1:0] out_q_reg;
    logic [N-1:0] out_q_next;
    logic         valid_q_reg;
    logic         valid_q_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign mux_sel[gi] = sel ? b[gi] : a[gi];
        end
    endgenerate

    assign out = mux_sel;

    // Next-state: capture the selected value when enabled, otherwise hold.
    always_comb begin
        out_q_next   = out_q_reg;
        valid_q_next = valid_q_reg;
        if (en) begin
            out_q_next   = mux_sel;
            valid_q_next = 1'b1;
        end
    end

    // Capture register; reset clears it immediately, release is edge-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_reg   <= '0;
            valid_q_reg <= 1'b0;
        end else begin
            out_q_reg   <= out_q_next;
            valid_q_reg <= valid_q_next;
        end
    end

    assign out_q   = out_q_reg;
    assign valid_q = valid_q_reg;

endmodule

// File: tb/tb_nbit_2to1_mux.sv
// Testbench for nbit_2to1_mux: directed steps followed by randomized cycles
// compared against a behavioural model, on N=4, N=1 and N=16 instances.
`timescale 1ns/1ps
module tb_nbit_2to1_mux;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        en;
    logic [3:0]  a4, b4, out4, out_q4;
    logic [0:0]  a1, b1, out1, out_q1;
    logic [15:0] a16, b16, out16, out_q16;
    logic        valid4, valid1, valid16;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the registered path.
    logic [3:0]  m_q4;
    logic [0:0]  m_q1;
    logic [15:0] m_q16;
    logic        m_v;

    nbit_2to1_mux #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .sel(sel), .en(en),
        .out(out4), .out_q(out_q4), .valid_q(valid4)
    );

    nbit_2to1_mux #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel), .en(en),
        .out(out1), .out_q(out_q1), .valid_q(valid1)
    );

    nbit_2to1_mux #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .sel(sel), .en(en),
        .out(out16), .out_q(out_q16), .valid_q(valid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_q4"},  16'(out_q4),  16'(m_q4));
        check({tag, "_q1"},  16'(out_q1),  16'(m_q1));
        check({tag, "_q16"}, out_q16,      m_q16);
        check({tag, "_v4"},  16'(valid4),  16'(m_v));
        check({tag, "_v1"},  16'(valid1),  16'(m_v));
        check({tag, "_v16"}, 16'(valid16), 16'(m_v));
    endtask

    task automatic check_comb(input string tag);
        check({tag, "_c4"},  16'(out4),  16'(sel ? b4 : a4));
        check({tag, "_c1"},  16'(out1),  16'(sel ? b1 : a1));
        check({tag, "_c16"}, out16,      sel ? b16 : a16);
    endtask

    // Model update for a rising edge with rst low.
    task automatic model_edge();
        if (!rst && en) begin
            m_q4  = sel ? b4 : a4;
            m_q1  = sel ? b1 : a1;
            m_q16 = sel ? b16 : a16;
            m_v   = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_q4 = '0; m_q1 = '0; m_q16 = '0; m_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sel = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;
        model_reset();
        #2;
        check_regs("reset");

        // Combinational select.
        a4 = 4'b1100; b4 = 4'b0011; sel = 1'b1;
        #1 check("comb_sel1", 16'(out4), 16'h0003);
        sel = 1'b0;
        #5 check("comb_sel0", 16'(out4), 16'h000C);
        a4 = 4'b1010;
        #1 check("track_a", 16'(out4), 16'h000A);
        b4 = 4'b1111;
        #1 check("ignore_b", 16'(out4), 16'h000A);

        // Registered capture after reset release.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; sel = 1'b1; a4 = 4'b1100; b4 = 4'b0011;
        @(posedge clk); #1;
        check("cap_q", 16'(out_q4), 16'h0003);
        check("cap_v", 16'(valid4), 16'h0001);
        @(negedge clk);
        en = 1'b0; sel = 1'b0;
        @(posedge clk); #1;
        check("hold_q", 16'(out_q4), 16'h0003);
        check("hold_out", 16'(out4), 16'h000C);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check("arst_q", 16'(out_q4), 16'h0000);
        check("arst_v", 16'(valid4), 16'h0000);
        en = 1'b1; sel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rsthold_q", 16'(out_q4), 16'h0000);
            check("rsthold_v", 16'(valid4), 16'h0000);
        end
        check("rst_comb", 16'(out4), 16'h0003);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        model_reset();

        // N=1 exhaustive select.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            sel = v[2]; a1 = v[1]; b1 = v[0];
            #1 check("n1_comb", 16'(out1), 16'(v[2] ? v[0] : v[1]));
        end

        // N=16 alternating select with capture.
        a16 = 16'hA5A5; b16 = 16'h5A5A; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel = i[0];
            #1 check("n16_comb", out16, i[0] ? 16'h5A5A : 16'hA5A5);
            model_edge();
            @(posedge clk); #1;
            check("n16_q", out_q16, i[0] ? 16'h5A5A : 16'hA5A5);
            check_regs("n16_regs");
        end

        // Randomized cycles against the model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            sel = 1'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 15) == 0);
            #1;
            check_comb("rnd");
            if (rst) begin
                model_reset();
                check_regs("rnd_arst");
            end
            model_edge();
            @(posedge clk); #1;
            check_regs("rnd_edge");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
